// File: rtl/pe_feeder_if.sv
// Memory-read and PE-side signal bundle for pe_feeder.
// The master side is the feeder; the slave side is the memory and my_pe pair.
interface pe_feeder_if #(
  parameter int unsigned L_RAM_SIZE = 4,
  parameter int unsigned DATA_W     = 32
);
  logic                  mem_en;
  logic [L_RAM_SIZE:0]   mem_addr;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  pe_aresetn;
  logic                  pe_we;
  logic [L_RAM_SIZE-1:0] pe_addr;
  logic [DATA_W-1:0]     pe_din;
  logic [DATA_W-1:0]     pe_ain;
  logic                  pe_valid;
  logic                  pe_dvalid;
  logic [DATA_W-1:0]     pe_dout;

  modport master (
    output mem_en, mem_addr,
    input  mem_rdata,
    output pe_aresetn, pe_we, pe_addr, pe_din, pe_ain, pe_valid,
    input  pe_dvalid, pe_dout
  );

  modport slave (
    input  mem_en, mem_addr,
    output mem_rdata,
    input  pe_aresetn, pe_we, pe_addr, pe_din, pe_ain, pe_valid,
    output pe_dvalid, pe_dout
  );
endinterface

// File: rtl/pe_feeder.sv
// Job sequencer for one my_pe: loads din into the PE RAM, streams ain one
// element per valid/dvalid handshake and captures the final PE output.
module pe_feeder #(
  parameter int unsigned L_RAM_SIZE = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  pe_feeder_if.master       bus
);

  localparam int unsigned KW = L_RAM_SIZE + 1;
  localparam int unsigned N  = 1 << L_RAM_SIZE;
  localparam logic [KW-1:0] LP_N    = KW'(N);
  localparam logic [KW-1:0] LP_LAST = KW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_CALC_RD, S_CALC_ISSUE, S_CALC_WAIT, S_DONE
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_W-1:0]     r_result;
  logic                  r_mem_en;
  logic [KW-1:0]         r_mem_addr;
  logic                  r_pe_aresetn;
  logic                  r_pe_we;
  logic [L_RAM_SIZE-1:0] r_pe_addr;
  logic [DATA_W-1:0]     r_pe_din;
  logic [DATA_W-1:0]     r_pe_ain;
  logic                  r_pe_valid;

  logic [KW-1:0]         w_k_inc;
  logic [KW-1:0]         w_ain_next;
  logic [L_RAM_SIZE-1:0] w_wr_addr;

  assign w_k_inc    = r_k + KW'(1);
  assign w_ain_next = LP_N + w_k_inc;
  assign w_wr_addr  = L_RAM_SIZE'(r_k - KW'(1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_pe_aresetn <= 1'b0;
      r_pe_we      <= 1'b0;
      r_pe_addr    <= '0;
      r_pe_din     <= '0;
      r_pe_ain     <= '0;
      r_pe_valid   <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_pe_we      <= 1'b0;
      r_pe_valid   <= 1'b0;
      r_pe_aresetn <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_pe_aresetn <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_state    <= S_LOAD;
          r_k        <= '0;
          r_mem_en   <= 1'b1;
          r_mem_addr <= '0;
        end
        // Step k issues read k+1 and writes the word returned for read k-1,
        // so the final (drain) step k==N only writes.
        S_LOAD: begin
          if (r_k != '0) begin
            r_pe_we   <= 1'b1;
            r_pe_addr <= w_wr_addr;
            r_pe_din  <= bus.mem_rdata;
          end
          if (r_k == LP_N) begin
            r_state    <= S_CALC_RD;
            r_k        <= '0;
            r_mem_en   <= 1'b1;
            r_mem_addr <= LP_N;
          end else begin
            r_k <= w_k_inc;
            if (r_k != LP_LAST) begin
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_k_inc;
            end
          end
        end
        S_CALC_RD: begin
          r_state <= S_CALC_ISSUE;
        end
        S_CALC_ISSUE: begin
          r_pe_ain   <= bus.mem_rdata;
          r_pe_addr  <= r_k[L_RAM_SIZE-1:0];
          r_pe_valid <= 1'b1;
          r_state    <= S_CALC_WAIT;
        end
        S_CALC_WAIT: begin
          if (bus.pe_dvalid) begin
            if (r_k == LP_LAST) begin
              r_result <= bus.pe_dout;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_k        <= w_k_inc;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_ain_next;
              r_state    <= S_CALC_RD;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign result         = r_result;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.pe_aresetn = r_pe_aresetn;
  assign bus.pe_we      = r_pe_we;
  assign bus.pe_addr    = r_pe_addr;
  assign bus.pe_din     = r_pe_din;
  assign bus.pe_ain     = r_pe_ain;
  assign bus.pe_valid   = r_pe_valid;

endmodule
